mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one external memory port between the instruction and
//               data caches. One command at a time is granted and forwarded;
//               read responses are steered back in issue order through a
//               small requester-ID FIFO.
//               Optional build macro MEM_ARB_RR_EN selects round-robin
//               arbitration; without it dc has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int RD_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic                   ic_req_rw,
    input  logic                   ic_req_data_valid,
    output logic                   ic_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,

    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_req_rw,
    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,

    output logic                   resp_err
);

    localparam int IDX_BITS = $clog2(RD_DEPTH);
    localparam int PTR_BITS = IDX_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_grant;
    logic                w_grant_next;
    logic                w_winner;
    logic                r_resp_err;

    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [RD_DEPTH-1:0] r_id_mem;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_head;

    logic                w_sel_valid;
    logic                w_sel_rw;
    logic                w_sel_data_valid;
    logic                w_cmd_valid;
    logic                w_cmd_fire;

    // Fields of the granted requester; address/data are always driven from it
    assign w_sel_valid       = r_grant ? dc_req_valid      : ic_req_valid;
    assign w_sel_rw          = r_grant ? dc_req_rw         : ic_req_rw;
    assign w_sel_data_valid  = r_grant ? dc_req_data_valid : ic_req_data_valid;
    assign mem_req_addr      = r_grant ? dc_req_addr       : ic_req_addr;
    assign mem_req_rw        = w_sel_rw;
    assign mem_req_data_bits = r_grant ? dc_req_data_bits  : ic_req_data_bits;
    assign mem_req_data_mask = r_grant ? dc_req_data_mask  : ic_req_data_mask;

    // A read may only be issued while there is room to remember who asked
    assign w_cmd_valid = (r_state == ST_CMD) && w_sel_valid && !(!w_sel_rw && w_full);
    assign w_cmd_fire  = w_cmd_valid && mem_req_ready;

`ifdef MEM_ARB_RR_EN
    logic r_last;

    // On a conflict the requester that did not win last time goes first
    assign w_winner = (ic_req_valid && dc_req_valid) ? ~r_last : dc_req_valid;

    // Remember who last got a command through to memory
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b0;
        end else if (w_cmd_fire) begin
            r_last <= r_grant;
        end
    end
`else
    // dc wins whenever it is asking
    assign w_winner = dc_req_valid;
`endif

    // State and grant registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    // Next-state and handshake steering
    always_comb begin
        w_state_next       = r_state;
        w_grant_next       = r_grant;
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        ic_req_data_ready  = 1'b0;
        dc_req_data_ready  = 1'b0;
        w_push             = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    w_grant_next = w_winner;
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                mem_req_valid = w_cmd_valid;
                if (r_grant) begin
                    dc_req_ready = w_cmd_fire;
                end else begin
                    ic_req_ready = w_cmd_fire;
                end
                if (!w_sel_valid) begin
                    w_state_next = ST_IDLE;
                end else if (w_cmd_fire) begin
                    if (w_sel_rw) begin
                        w_state_next = ST_WDATA;
                    end else begin
                        w_push       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_WDATA: begin
                mem_req_data_valid = w_sel_data_valid;
                if (r_grant) begin
                    dc_req_data_ready = mem_req_data_ready;
                end else begin
                    ic_req_data_ready = mem_req_data_ready;
                end
                if (w_sel_data_valid && mem_req_data_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ID FIFO status; pointers carry one extra wrap bit
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_BITS] != r_rd_ptr[IDX_BITS]) &&
                     (r_wr_ptr[IDX_BITS-1:0] == r_rd_ptr[IDX_BITS-1:0]);
    assign w_pop   = mem_resp_valid && !w_empty;
    assign w_head  = r_id_mem[r_rd_ptr[IDX_BITS-1:0]];

    // Responses are steered in the cycle they arrive
    assign ic_resp_valid = w_pop && !w_head;
    assign dc_resp_valid = w_pop && w_head;
    assign ic_resp_data  = mem_resp_data;
    assign dc_resp_data  = mem_resp_data;
    assign resp_err      = r_resp_err;

    // FIFO pointers and the sticky orphan-response flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            end
            if (mem_resp_valid && w_empty) begin
                r_resp_err <= 1'b1;
            end
        end
    end

    // ID storage; contents are meaningless until pointed at by a push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_id_mem[r_wr_ptr[IDX_BITS-1:0]] <= r_grant;
        end
    end

endmodule
`default_nettype wire
